if_pc_fetch: RTL and testbench
==============================

IF_PC_FETCH -- requirements
Module: if_pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-004 Port i_jump_flag, input, 1, SHALL be the taken-branch/jump indication from the EX-stage branch ALU.
REQ-005 Port i_jump_addr, input, 32, SHALL be the redirect target from the EX-stage branch ALU.
REQ-006 Port i_stall, input, 1, SHALL mean decode cannot accept o_inst this cycle.
REQ-007 Port o_imem_req, output, 1, SHALL be the instruction-memory request valid.
REQ-008 Port o_imem_addr, output, 32, SHALL be the request address.
REQ-009 Port i_imem_gnt, input, 1, SHALL mean the request is accepted this cycle.
REQ-010 Port i_imem_rvalid, input, 1, SHALL mean i_imem_rdata holds the response.
REQ-011 Port i_imem_rdata, input, 32, SHALL be the returned instruction word.
REQ-012 Port o_inst_valid, output, 1, SHALL mean o_inst/o_inst_pc hold a live instruction for decode.
REQ-013 Port o_inst, output, 32, SHALL be the fetched instruction.
REQ-014 Port o_inst_pc, output, 32, SHALL be the address o_inst was fetched from.
REQ-015 Port o_flush, output, 1, SHALL tell IF/ID and ID/EX registers to squash their contents.

Function
REQ-016 States SHALL be S_RESET, S_REQ, S_WAIT, S_DROP; exactly one request outstanding at any time.
REQ-017 S_RESET SHALL last one cycle after rst_n rises, then go to S_REQ with pc = RESET_PC.
REQ-018 In S_REQ, o_imem_req SHALL be 1 unless (o_inst_valid and i_stall), with o_imem_addr = pc.
REQ-019 In S_REQ, on o_imem_req and i_imem_gnt the block SHALL record req_pc = pc, set pc = pc + 4 (32-bit wrap), and go to S_WAIT.
REQ-020 In S_WAIT, on i_imem_rvalid the block SHALL load o_inst = i_imem_rdata, o_inst_pc = req_pc, set o_inst_valid = 1, and go to S_REQ.
REQ-021 o_inst_valid SHALL clear when decode consumes it (o_inst_valid and not i_stall) unless a response loads it the same edge.
REQ-022 While o_inst_valid and i_stall, o_inst, o_inst_pc and pc SHALL hold.
REQ-023 o_flush SHALL equal i_jump_flag combinationally, except 0 in S_RESET.
REQ-024 On i_jump_flag, pc SHALL load {i_jump_addr[31:2], 2'b00} and o_inst_valid SHALL clear at that edge.
REQ-025 Jump SHALL have priority over i_stall and over any same-cycle response or grant.
REQ-026 Jump in S_WAIT without rvalid, or in S_REQ with gnt, SHALL go to S_DROP.
REQ-027 Jump in S_WAIT with rvalid, or in S_REQ without gnt, SHALL discard the data and go to S_REQ.
REQ-028 In S_DROP, the next i_imem_rvalid SHALL be discarded and the state SHALL go to S_REQ; a second jump in S_DROP SHALL only update pc.
REQ-029 i_imem_rvalid in S_RESET or S_REQ SHALL be ignored.
REQ-030 Fetch-to-decode latency SHALL be grant cycle + memory latency + 1 edge; back-to-back zero-wait memory SHALL sustain one instruction per 2 cycles.

Reset
REQ-031 Reset SHALL force S_RESET, pc = RESET_PC, o_imem_req = 0, o_imem_addr = RESET_PC, o_inst_valid = 0, o_inst = 32'h0000_0013 (NOP), o_inst_pc = 0, o_flush = 0.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request without waiting for its response.

Structure
REQ-033 NOP encoding, state encodings and RESET_PC default SHALL live in the shared defines include.
REQ-034 The block SHALL be a single module; the instruction output register MAY be sub-module if_inst_buf.

Verification
REQ-035 Reset release, zero-wait memory returning 0x00A00093 at 0x0 -> o_inst_valid on cycle 3 with o_inst_pc = 0x0; next request at 0x4.
REQ-036 Response to 0x8 pending, i_jump_flag with addr 0x103 -> o_flush = 1, S_DROP; stale rvalid discarded; next request at 0x100.
REQ-037 o_inst_valid with i_stall held 5 cycles -> o_imem_req = 0, o_inst/o_inst_pc stable; stall released -> request resumes at next pc.
REQ-038 Jump, i_stall and rvalid in the same cycle -> rvalid data dropped, o_inst_valid = 0 next cycle, pc = target.
REQ-039 pc = 0xFFFF_FFFC granted -> pc wraps to 0x0000_0000.
REQ-040 rst_n asserted during S_WAIT, then late rvalid after release -> ignored; first o_inst_pc = RESET_PC.

Source files
------------

// File: rtl/if_pc_fetch_pkg.sv
// Shared constants, state encoding and payload types for the IF-stage fetch unit.
package if_pc_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'h0000_0003;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_e;

  // Instruction word paired with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_rsp_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// IF/ID instruction holding register: loads on a response, drains when decode takes it.
module if_inst_buf
  import if_pc_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic            stall,
  input  fetch_rsp_t      rsp,
  output logic            valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);

  // Clear (redirect) beats load; a held instruction drains once decode is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= rsp.inst;
      pc    <= rsp.pc;
    end else if (valid && !stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_pc_fetch.sv
// Instruction-fetch stage: single-outstanding imem requester with EX-stage redirect and flush.
module if_pc_fetch
  import if_pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_jump_flag,
  input  logic [XLEN-1:0] i_jump_addr,
  input  logic            i_stall,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_flush
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            handshake;
  logic            buf_load;
  logic            buf_clear;
  fetch_rsp_t      rsp;

  assign o_imem_addr = pc_q;
  assign rsp         = '{inst: i_imem_rdata, pc: req_pc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    handshake  = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    o_imem_req = 1'b0;
    o_flush    = 1'b0;

    unique case (state_q)
      S_RESET: begin
        state_d = S_REQ;
        pc_d    = RESET_PC;
      end
      S_REQ: begin
        // Back-pressure: no new fetch while decode is sitting on an unconsumed word.
        o_imem_req = !(o_inst_valid && i_stall);
        handshake  = o_imem_req && i_imem_gnt;
        if (handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          buf_load = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_DROP: begin
        if (i_imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_RESET;
    endcase

    // Redirect overrides stall, grant and response; an in-flight fetch is drained in S_DROP.
    if (i_jump_flag && (state_q != S_RESET)) begin
      o_flush   = 1'b1;
      buf_clear = 1'b1;
      buf_load  = 1'b0;
      pc_d      = align_pc(i_jump_addr);
      if (state_q == S_REQ) begin
        state_d = handshake ? S_DROP : S_REQ;
      end else if (state_q == S_WAIT) begin
        state_d = i_imem_rvalid ? S_REQ : S_DROP;
      end
    end
  end

  if_inst_buf u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .stall (i_stall),
    .rsp   (rsp),
    .valid (o_inst_valid),
    .inst  (o_inst),
    .pc    (o_inst_pc)
  );

endmodule

// File: tb/tb_if_pc_fetch.sv
// Self-checking bench for if_pc_fetch: directed vector table, corner sequences, random stream model.
module tb_if_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        i_jump_flag;
  logic [31:0] i_jump_addr;
  logic        i_stall;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_flush;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_jump_flag   (i_jump_flag),
    .i_jump_addr   (i_jump_addr),
    .i_stall       (i_stall),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .o_flush       (o_flush)
  );

  typedef struct {
    logic        st;
    logic        jf;
    logic [31:0] ja;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_flush;
    logic        e_v;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vt[24];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic st, input logic jf, input logic [31:0] ja,
                       input logic g, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    i_stall       = st;
    i_jump_flag   = jf;
    i_jump_addr   = ja;
    i_imem_gnt    = g;
    i_imem_rvalid = rv;
    i_imem_rdata  = rd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Reset held across two rising edges; released between edges so the next drive sees S_RESET.
  task automatic apply_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    i_stall       = 1'b0;
    i_jump_flag   = 1'b0;
    i_jump_addr   = 32'h0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // Random run: memory with random grant and latency, decode with random stall, occasional redirects.
  // Expected stream: consecutive word addresses from RESET_PC, restarting at each aligned jump target.
  task automatic random_run(input int cycles);
    logic        st, jf, g, rv;
    logic [31:0] ja, rd;
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    logic [31:0] exp_pc;
    int          delivered;
    pend      = 1'b0;
    paddr     = 32'h0;
    cnt       = 0;
    exp_pc    = 32'h0;
    delivered = 0;
    apply_reset();
    idle();
    for (int c = 0; c < cycles; c++) begin
      st = ($urandom_range(0, 3) == 0);
      jf = ($urandom_range(0, 31) == 0);
      ja = $urandom;
      g  = ($urandom_range(0, 3) != 0);
      rv = pend && (cnt == 0);
      rd = rv ? mem_word(paddr) : $urandom;
      drive(st, jf, ja, g, rv, rd);
      check1("rnd_flush", o_flush, jf);
      check1("rnd_one_outstanding", o_imem_req && pend, 1'b0);
      if (o_inst_valid && st) check1("rnd_stall_blocks_req", o_imem_req, 1'b0);
      if (o_inst_valid && !st && !jf) begin
        check32("rnd_inst_pc", o_inst_pc, exp_pc);
        check32("rnd_inst", o_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (jf) exp_pc = ja & 32'hFFFF_FFFC;
      if (rv) pend = 1'b0;
      else if (pend) cnt--;
      if (o_imem_req && g) begin
        pend  = 1'b1;
        paddr = o_imem_addr;
        cnt   = $urandom_range(0, 2);
      end
    end
    check1("rnd_throughput", delivered >= 100, 1'b1);
  endtask

  initial begin
    rst_n         = 1'b0;
    i_stall       = 1'b0;
    i_jump_flag   = 1'b0;
    i_jump_addr   = 32'h0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;

    //        st    jf    ja            g     rv    rd              req   addr          fl    v     inst            ipc
    vt[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0013, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 1'b0, 32'h0000_0013, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h00A0_0093, 1'b0, 32'h4,       1'b0, 1'b0, 32'h0000_0013, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         1'b1, 32'h4,       1'b0, 1'b1, 32'h00A0_0093, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'h4,       1'b0, 1'b0, 32'h00A0_0093, 32'h0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h8,       1'b0, 1'b0, 32'h00A0_0093, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b0, 32'h8,       1'b0, 1'b1, 32'h1111_1111, 32'h4};
    vt[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'h8,       1'b0, 1'b1, 32'h1111_1111, 32'h4};
    vt[8]  = '{1'b0, 1'b1, 32'h103,     1'b0, 1'b0, 32'h0,         1'b0, 32'hC,       1'b1, 1'b0, 32'h1111_1111, 32'h4};
    vt[9]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h100,     1'b0, 1'b0, 32'h1111_1111, 32'h4};
    vt[10] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'h100,     1'b0, 1'b0, 32'h1111_1111, 32'h4};
    vt[11] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h104,     1'b0, 1'b0, 32'h1111_1111, 32'h4};
    vt[12] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'h104,     1'b0, 1'b1, 32'h2222_2222, 32'h100};
    vt[13] = '{1'b1, 1'b1, 32'h200,     1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h108,     1'b1, 1'b0, 32'h2222_2222, 32'h100};
    vt[14] = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         1'b1, 32'h200,     1'b0, 1'b0, 32'h2222_2222, 32'h100};
    vt[15] = '{1'b0, 1'b1, 32'h3FF,     1'b1, 1'b0, 32'h0,         1'b1, 32'h200,     1'b1, 1'b0, 32'h2222_2222, 32'h100};
    vt[16] = '{1'b0, 1'b1, 32'h500,     1'b0, 1'b0, 32'h0,         1'b0, 32'h3FC,     1'b1, 1'b0, 32'h2222_2222, 32'h100};
    vt[17] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h500,     1'b0, 1'b0, 32'h2222_2222, 32'h100};
    vt[18] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'h500,     1'b0, 1'b0, 32'h2222_2222, 32'h100};
    vt[19] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         1'b0, 32'h504,     1'b0, 1'b0, 32'h2222_2222, 32'h100};
    vt[20] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h4444_4444, 1'b0, 32'h504,     1'b0, 1'b0, 32'h2222_2222, 32'h100};
    vt[21] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         1'b1, 32'h504,     1'b0, 1'b1, 32'h4444_4444, 32'h500};
    vt[22] = '{1'b0, 1'b1, 32'h600,     1'b0, 1'b0, 32'h0,         1'b1, 32'h504,     1'b1, 1'b0, 32'h4444_4444, 32'h500};
    vt[23] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         1'b1, 32'h600,     1'b0, 1'b0, 32'h4444_4444, 32'h500};

    // Reset values, with a jump request asserted to confirm flush stays low in reset.
    @(negedge clk);
    i_jump_flag = 1'b1;
    #1;
    check1("rst_req", o_imem_req, 1'b0);
    check32("rst_addr", o_imem_addr, 32'h0);
    check1("rst_valid", o_inst_valid, 1'b0);
    check32("rst_inst", o_inst, 32'h0000_0013);
    check32("rst_inst_pc", o_inst_pc, 32'h0);
    check1("rst_flush", o_flush, 1'b0);
    apply_reset();

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].st, vt[i].jf, vt[i].ja, vt[i].g, vt[i].rv, vt[i].rd);
      check1($sformatf("vec%0d_req", i), o_imem_req, vt[i].e_req);
      check32($sformatf("vec%0d_addr", i), o_imem_addr, vt[i].e_addr);
      check1($sformatf("vec%0d_flush", i), o_flush, vt[i].e_flush);
      check1($sformatf("vec%0d_valid", i), o_inst_valid, vt[i].e_v);
      check32($sformatf("vec%0d_inst", i), o_inst, vt[i].e_inst);
      check32($sformatf("vec%0d_inst_pc", i), o_inst_pc, vt[i].e_ipc);
    end

    // Decode stall held five cycles: no request, instruction frozen; resumes at the next pc.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check1("stl_req0", o_imem_req, 1'b1);
    check32("stl_addr0", o_imem_addr, 32'h600);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check1($sformatf("stl%0d_req", k), o_imem_req, 1'b0);
      check1($sformatf("stl%0d_valid", k), o_inst_valid, 1'b1);
      check32($sformatf("stl%0d_inst", k), o_inst, 32'h5555_5555);
      check32($sformatf("stl%0d_inst_pc", k), o_inst_pc, 32'h600);
      check32($sformatf("stl%0d_addr", k), o_imem_addr, 32'h604);
    end
    idle();
    check1("stl_resume_req", o_imem_req, 1'b1);
    check32("stl_resume_addr", o_imem_addr, 32'h604);
    check1("stl_resume_valid", o_inst_valid, 1'b1);

    // pc wrap at the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    check1("wrap_flush", o_flush, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check1("wrap_req", o_imem_req, 1'b1);
    check32("wrap_addr_top", o_imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_6666);
    check32("wrap_addr_zero", o_imem_addr, 32'h0);
    idle();
    check1("wrap_valid", o_inst_valid, 1'b1);
    check32("wrap_inst_pc", o_inst_pc, 32'hFFFF_FFFC);
    check32("wrap_inst", o_inst, 32'h6666_6666);

    // Reset while a fetch is outstanding; its late response must be ignored.
    drive(1'b0, 1'b1, 32'h7000, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check32("mrst_pre_addr", o_imem_addr, 32'h7000);
    @(negedge clk);
    i_imem_gnt  = 1'b0;
    i_jump_flag = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check1("mrst_req", o_imem_req, 1'b0);
    check32("mrst_addr", o_imem_addr, 32'h0);
    check1("mrst_valid", o_inst_valid, 1'b0);
    check32("mrst_inst", o_inst, 32'h0000_0013);
    check1("mrst_flush", o_flush, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0001);
    check1("mrst_late_req", o_imem_req, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0002);
    check1("mrst_sreq_req", o_imem_req, 1'b1);
    check32("mrst_sreq_addr", o_imem_addr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check1("mrst_ignored_valid", o_inst_valid, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
    idle();
    check1("mrst_first_valid", o_inst_valid, 1'b1);
    check32("mrst_first_pc", o_inst_pc, 32'h0);
    check32("mrst_first_inst", o_inst, 32'h7777_7777);

    random_run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
